// File: rtl/bf16_pkg.sv
// Shared bfloat16 field widths, encodings and enums for the bf16 datapath blocks.
package bf16_pkg;
  localparam int E = 8;
  localparam int M = 7;
  localparam int BIAS = 127;
  localparam logic [E-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} cvt_state_e;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} bf16_class_e;
endpackage

// File: rtl/bf16_classify.sv
// Combinational bf16 operand classifier; subnormals are flushed to ZERO.
module bf16_classify
  import bf16_pkg::*;
(
  input  logic         s_i,
  input  logic [E-1:0] e_i,
  input  logic [M-1:0] m_i,
  output bf16_class_e  cls_o,
  output logic         neg_o
);
  always_comb begin
    cls_o = NORM;
    if (e_i == '0) begin
      cls_o = ZERO;
    end else if (e_i == EXP_MAX) begin
      cls_o = (m_i == '0) ? INF : NAN;
    end
  end

  // Sign of a nonzero operand; -0 is treated as positive.
  assign neg_o = s_i && (cls_o != ZERO);
endmodule

// File: rtl/bf16_to_int.sv
// bf16 {s,e,m} to W-bit signed integer, round toward zero, 1-bit-per-cycle aligner.
// Specials resolve in one cycle; normals take max(count,1)+2 cycles.
module bf16_to_int
  import bf16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         s_i,
  input  logic [E-1:0] e_i,
  input  logic [M-1:0] m_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] int_o,
  output logic         inexact_o,
  output logic         ovf_o,
  output logic         invalid_o
);
  localparam int WR = W + 8;
  localparam int CW = 5;
  localparam logic signed [8:0] U_TOP = 9'(W - 1);
  localparam logic signed [8:0] U_PT  = 9'sd7;

  bf16_class_e cls;
  logic        neg;

  bf16_classify u_classify (
    .s_i   (s_i),
    .e_i   (e_i),
    .m_i   (m_i),
    .cls_o (cls),
    .neg_o (neg)
  );

  logic signed [8:0] u;
  logic [W-1:0]      sat_val;
  logic [CW-1:0]     cnt_d;
  logic              left_d;

  assign u       = 9'({1'b0, e_i}) - 9'(BIAS);
  assign sat_val = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign left_d  = (u >= U_PT);
  assign cnt_d   = left_d ? CW'(u - U_PT) : CW'(U_PT - u);

  cvt_state_e    state_q;
  logic [WR-1:0] work_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  int_q;
  logic          left_q, sign_q, ready_q, valid_q, inx_q, ovf_q, inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      int_q   <= '0;
      inx_q   <= 1'b0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            inx_q   <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            int_q   <= '0;
            sign_q  <= neg;
            work_q  <= {{W{1'b0}}, 1'b1, m_i};
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            ready_q <= 1'b0;
            state_q <= DONE;
            valid_q <= 1'b1;
            if (cls == NAN) begin
              inv_q <= 1'b1;
            end else if (cls == INF) begin
              int_q <= sat_val;
              ovf_q <= 1'b1;
            end else if (cls == ZERO) begin
              int_q <= '0;
            end else if (u[8]) begin
              inx_q <= 1'b1;
            end else if (u >= U_TOP) begin
              // -2^(W-1) is the one representable value at the top exponent.
              int_q <= sat_val;
              ovf_q <= !(neg && (u == U_TOP) && (m_i == '0));
            end else begin
              state_q <= SHIFT;
              valid_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            if (left_q) begin
              work_q <= work_q << 1;
            end else begin
              work_q <= work_q >> 1;
              inx_q  <= inx_q | work_q[0];
            end
            cnt_q <= cnt_q - CW'(1);
          end
          if (cnt_q <= CW'(1)) state_q <= NEG;
        end
        NEG: begin
          int_q   <= sign_q ? (~work_q[W-1:0] + W'(1)) : work_q[W-1:0];
          state_q <= DONE;
          valid_q <= 1'b1;
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign int_o     = int_q;
  assign inexact_o = inx_q;
  assign ovf_o     = ovf_q;
  assign invalid_o = inv_q;
endmodule
